// File: rtl/jtframe_dwnld_sched.sv
// Download scheduler: ioctl ROM bytes -> bank-mapped FIFO -> one SDRAM prog_we write at a time.
// Optional macro JTFRAME_DWNLD_MERGE_EN pairs even/odd bytes of one word into a single write.
module jtframe_dwnld_sched #(
   parameter logic [24:0] BA1_START = 25'h080000,
   parameter logic [24:0] BA2_START = 25'h100000,
   parameter logic [24:0] BA3_START = 25'h180000,
   parameter int unsigned FIFO_AW   = 2
)(
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        downloading,
   input  logic        ioctl_rom_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   output logic [21:0] prog_addr,
   output logic [15:0] prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_bank,
   output logic        prog_we,
   input  logic        prog_rdy,
   output logic        dwnld_busy,
   output logic        ovf
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CNT_W = FIFO_AW + 1;

   typedef struct packed {
      logic [1:0]  bank;
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  mask;
   } entry_t;

   typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

   state_t             state, state_nx;
   entry_t             in_e, push_e, head;
   entry_t             mem [0:DEPTH-1];
   logic [22:0]        off;
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               empty, full, push, do_push, pop;
   logic               pend_empty, dl_d, dl_rise;
   logic [21:0]        addr_nx;
   logic [15:0]        data_nx;
   logic [1:0]         mask_nx, bank_nx;
   logic               we_nx;

   // only the low 23 offset bits reach the word address, so subtract on that slice
   always_comb begin
      in_e = '0;
      off  = ioctl_addr[22:0];
      if (ioctl_addr >= BA3_START) begin
         in_e.bank = 2'd3;
         off       = ioctl_addr[22:0] - BA3_START[22:0];
      end else if (ioctl_addr >= BA2_START) begin
         in_e.bank = 2'd2;
         off       = ioctl_addr[22:0] - BA2_START[22:0];
      end else if (ioctl_addr >= BA1_START) begin
         in_e.bank = 2'd1;
         off       = ioctl_addr[22:0] - BA1_START[22:0];
      end
      in_e.addr = off[22:1];
      in_e.data = {ioctl_data, ioctl_data};
      in_e.mask = off[0] ? 2'b01 : 2'b10;
   end

   assign dl_rise = downloading & ~dl_d;

`ifdef JTFRAME_DWNLD_MERGE_EN
   entry_t pend, pend_nx;
   logic   pend_v, pend_v_nx, pend_go, pend_go_nx, dl_fall;

   assign dl_fall = ~downloading & dl_d;

   // pend_go marks a held entry that must be pushed on the next cycle (odd-byte stall or late flush)
   always_comb begin
      push       = 1'b0;
      push_e     = pend;
      pend_nx    = pend;
      pend_v_nx  = pend_v;
      pend_go_nx = pend_go;
      if (pend_v && pend_go) begin
         push       = 1'b1;
         pend_v_nx  = 1'b0;
         pend_go_nx = 1'b0;
      end else if (ioctl_rom_wr) begin
         if (in_e.mask == 2'b10) begin
            push       = pend_v;
            pend_nx    = in_e;
            pend_v_nx  = 1'b1;
            pend_go_nx = 1'b0;
         end else if (pend_v && pend.bank == in_e.bank && pend.addr == in_e.addr) begin
            push        = 1'b1;
            push_e.data = {ioctl_data, pend.data[7:0]};
            push_e.mask = 2'b00;
            pend_v_nx   = 1'b0;
         end else if (pend_v) begin
            push       = 1'b1;
            pend_nx    = in_e;
            pend_go_nx = 1'b1;
         end else begin
            push   = 1'b1;
            push_e = in_e;
         end
      end else if (pend_v && dl_fall) begin
         push      = 1'b1;
         pend_v_nx = 1'b0;
      end
      if (dl_fall && pend_v_nx) pend_go_nx = 1'b1;
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         pend    <= '0;
         pend_v  <= 1'b0;
         pend_go <= 1'b0;
      end else begin
         pend    <= pend_nx;
         pend_v  <= pend_v_nx;
         pend_go <= pend_go_nx;
      end
   end

   assign pend_empty = ~pend_v;
`else
   assign push       = ioctl_rom_wr;
   assign push_e     = in_e;
   assign pend_empty = 1'b1;
`endif

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push & ~full;
   assign pop     = (state == IDLE) & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= push_e;
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      addr_nx  = prog_addr;
      data_nx  = prog_data;
      mask_nx  = prog_mask;
      bank_nx  = prog_bank;
      we_nx    = prog_we;
      case (state)
         IDLE: if (!empty) begin
            state_nx = WAIT;
            addr_nx  = head.addr;
            data_nx  = head.data;
            mask_nx  = head.mask;
            bank_nx  = head.bank;
            we_nx    = 1'b1;
         end
         WAIT: if (prog_rdy) begin
            state_nx = GAP;
            we_nx    = 1'b0;
            mask_nx  = 2'b11;
         end
         GAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         prog_addr <= '0;
         prog_data <= '0;
         prog_mask <= '1;
         prog_bank <= '0;
         prog_we   <= 1'b0;
      end else begin
         state     <= state_nx;
         prog_addr <= addr_nx;
         prog_data <= data_nx;
         prog_mask <= mask_nx;
         prog_bank <= bank_nx;
         prog_we   <= we_nx;
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         dl_d       <= 1'b0;
         dwnld_busy <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         dl_d <= downloading;
         if (dl_rise)
            dwnld_busy <= 1'b1;
         else if (!downloading && empty && state == IDLE && pend_empty)
            dwnld_busy <= 1'b0;
         if (dl_rise)      ovf <= 1'b0;
         if (push && full) ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jtframe_dwnld_sched.sv
// Self-checking bench for jtframe_dwnld_sched: directed and random writes against a bank-arithmetic model.
module tb_jtframe_dwnld_sched;

   logic        clk_sys = 1'b0;
   logic        rst, downloading, ioctl_rom_wr, prog_rdy;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask, prog_bank;
   logic        prog_we, dwnld_busy, ovf;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0]  bank;
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  mask;
   } exp_t;

   exp_t exp_q[$];

   jtframe_dwnld_sched dut (
      .clk_sys     (clk_sys),
      .rst         (rst),
      .downloading (downloading),
      .ioctl_rom_wr(ioctl_rom_wr),
      .ioctl_addr  (ioctl_addr),
      .ioctl_data  (ioctl_data),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_mask   (prog_mask),
      .prog_bank   (prog_bank),
      .prog_we     (prog_we),
      .prog_rdy    (prog_rdy),
      .dwnld_busy  (dwnld_busy),
      .ovf         (ovf)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // banks are 512 KiB regions; anything past bank 3's start stays in bank 3
   function automatic exp_t model(input logic [24:0] a, input logic [7:0] d);
      exp_t e;
      int unsigned region, offs;
      region = 32'(a) / 32'h80000;
      if (region > 3) region = 3;
      offs   = 32'(a) - region * 32'h80000;
      e.bank = 2'(region);
      e.addr = 22'(offs >> 1);
      e.data = {d, d};
      e.mask = (offs % 2 == 1) ? 2'b01 : 2'b10;
      return e;
   endfunction

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr   = a;
      ioctl_data   = d;
      ioctl_rom_wr = 1'b1;
      tick();
      ioctl_rom_wr = 1'b0;
   endtask

   task automatic service(input exp_t e, input int unsigned hold);
      int unsigned n = 0;
      while (!prog_we && n < 50) begin
         tick();
         n++;
      end
      chk("we_seen", 32'(prog_we), 32'd1);
      chk("bank", 32'(prog_bank), 32'(e.bank));
      chk("addr", 32'(prog_addr), 32'(e.addr));
      chk("data", 32'(prog_data), 32'(e.data));
      chk("mask", 32'(prog_mask), 32'(e.mask));
      repeat (hold) begin
         tick();
         chk("we_hold", 32'(prog_we), 32'd1);
         chk("addr_hold", 32'(prog_addr), 32'(e.addr));
      end
      prog_rdy = 1'b1;
      tick();
      prog_rdy = 1'b0;
      chk("we_drop", 32'(prog_we), 32'd0);
      chk("mask_idle", 32'(prog_mask), 32'd3);
   endtask

   initial begin
      exp_t e;
      logic [24:0] a;
      logic [7:0]  d;
      int unsigned n;

      rst = 1'b1; downloading = 1'b0; ioctl_rom_wr = 1'b0; prog_rdy = 1'b0;
      ioctl_addr = '0; ioctl_data = '0;
      repeat (3) tick();
      chk("rst_addr", 32'(prog_addr), 32'd0);
      chk("rst_data", 32'(prog_data), 32'd0);
      chk("rst_mask", 32'(prog_mask), 32'd3);
      chk("rst_bank", 32'(prog_bank), 32'd0);
      chk("rst_we", 32'(prog_we), 32'd0);
      chk("rst_busy", 32'(dwnld_busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      tick();
      downloading = 1'b1;
      tick();
      chk("busy_rise", 32'(dwnld_busy), 32'd1);

`ifdef JTFRAME_DWNLD_MERGE_EN
      wr_byte(25'h000010, 8'h11);
      tick();
      wr_byte(25'h000011, 8'h22);
      e.bank = 2'd0; e.addr = 22'h8; e.data = 16'h2211; e.mask = 2'b00;
      service(e, 1);
      wr_byte(25'h000020, 8'h33);
      repeat (4) begin
         tick();
         chk("pend_hold", 32'(prog_we), 32'd0);
      end
      chk("pend_busy", 32'(dwnld_busy), 32'd1);
      downloading = 1'b0;
      e.bank = 2'd0; e.addr = 22'h10; e.data = 16'h3333; e.mask = 2'b10;
      service(e, 0);
      n = 0;
      while (dwnld_busy && n < 2) begin
         tick();
         n++;
      end
      chk("merge_busy_fall", 32'(dwnld_busy), 32'd0);
`else
      // first write: two edges from the sampled strobe to prog_we
      wr_byte(25'h000000, 8'h5A);
      chk("lat_edge1", 32'(prog_we), 32'd0);
      tick();
      chk("lat_edge2", 32'(prog_we), 32'd1);
      service(model(25'h000000, 8'h5A), 0);

      wr_byte(25'h080005, 8'hA5);
      service(model(25'h080005, 8'hA5), 1);
      wr_byte(25'h17FFFF, 8'h3C);
      e.bank = 2'd2; e.addr = 22'h3FFFF; e.data = 16'h3C3C; e.mask = 2'b01;
      service(e, 1);
      wr_byte(25'h180000, 8'hC3);
      e.bank = 2'd3; e.addr = 22'h0; e.data = 16'hC3C3; e.mask = 2'b10;
      service(e, 1);

      for (int i = 0; i < 16; i++) begin
         a = 25'($urandom);
         d = 8'($urandom);
         wr_byte(a, d);
         chk("rnd_lat1", 32'(prog_we), 32'd0);
         tick();
         chk("rnd_lat2", 32'(prog_we), 32'd1);
         service(model(a, d), $urandom_range(0, 3));
      end

      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(2, 5);
         for (int k = 0; k < int'(n); k++) begin
            a = 25'($urandom);
            d = 8'($urandom);
            wr_byte(a, d);
            exp_q.push_back(model(a, d));
         end
         while (exp_q.size() > 0) service(exp_q.pop_front(), $urandom_range(0, 2));
      end

      // overflow: one in flight plus four queued, sixth byte dropped
      for (int k = 0; k < 6; k++) begin
         a = 25'($urandom);
         d = 8'($urandom);
         wr_byte(a, d);
         if (k < 5) exp_q.push_back(model(a, d));
         if (k == 4) chk("ovf_before", 32'(ovf), 32'd0);
      end
      chk("ovf_set", 32'(ovf), 32'd1);
      while (exp_q.size() > 0) service(exp_q.pop_front(), 1);
      tick();
      chk("ovf_idle", 32'(prog_we), 32'd0);
      downloading = 1'b0;
      tick();
      tick();
      chk("ovf_sticky", 32'(ovf), 32'd1);
      downloading = 1'b1;
      tick();
      chk("ovf_clear", 32'(ovf), 32'd0);

      // busy survives the downloading fall until the queue drains
      for (int k = 0; k < 3; k++) begin
         a = 25'($urandom);
         d = 8'($urandom);
         wr_byte(a, d);
         exp_q.push_back(model(a, d));
      end
      downloading = 1'b0;
      tick();
      chk("busy_pending", 32'(dwnld_busy), 32'd1);
      service(exp_q.pop_front(), 0);
      chk("busy_after1", 32'(dwnld_busy), 32'd1);
      service(exp_q.pop_front(), 0);
      chk("busy_after2", 32'(dwnld_busy), 32'd1);
      service(exp_q.pop_front(), 0);
      n = 0;
      while (dwnld_busy && n < 2) begin
         tick();
         n++;
      end
      chk("busy_fall", 32'(dwnld_busy), 32'd0);

      // reset while waiting on prog_rdy
      downloading = 1'b1;
      tick();
      wr_byte(25'h0ABCDE, 8'h77);
      tick();
      chk("wait_we", 32'(prog_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_we", 32'(prog_we), 32'd0);
      chk("rst_async_busy", 32'(dwnld_busy), 32'd0);
      tick();
      rst = 1'b0;
      n = 0;
      repeat (10) begin
         tick();
         if (prog_we) n++;
      end
      chk("no_write_after_rst", 32'(n), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
